// File: rtl/lkp_rep_pkg.sv
// Shared definitions for the lookup-reply protocol.
// Header layout, flag encodings and keep-mask helper.
package lkp_rep_pkg;

    localparam int HDR_BYTES  = 11;
    localparam int HDR_BITS   = HDR_BYTES * 8;
    localparam int HOLD_BYTES = 64 - HDR_BYTES;
    localparam int HOLD_BITS  = HOLD_BYTES * 8;

    localparam logic [15:0] HOLD_LEN = 16'(HOLD_BYTES);

    localparam logic [7:0] FLAG_HIT  = 8'hFF;
    localparam logic [7:0] FLAG_MISS = 8'h00;

    localparam int FLAG_LSB = 0;
    localparam int LEN_LSB  = 8;
    localparam int KEY_LSB  = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BODY,
        ST_FLUSH,
        ST_DROP
    } rx_state_t;

    typedef struct packed {
        logic [63:0] key;
        logic        hit;
        logic [15:0] len;
    } meta_t;

    typedef struct packed {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
    } ram_t;

    function automatic logic [63:0] gen_keep(input logic [6:0] count);
        logic [63:0] k;
        for (int i = 0; i < 64; i++)
            k[i] = (7'(i) < count);
        return k;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-entry valid/ready output register.
// Loads only when the slot is free; holds data until accepted.
module axis_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic         free,
    output logic         valid,
    output logic [W-1:0] q,
    input  logic         ready
);

    assign free = !valid || ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/lkp_rep_receiver.sv
// Lookup-reply receiver: parses the 11-byte header and
// realigns the value payload to byte 0 of a 512-bit stream.
module lkp_rep_receiver
    import lkp_rep_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         s_axis_rx_tvalid,
    input  logic [511:0] s_axis_rx_tdata,
    input  logic [63:0]  s_axis_rx_tkeep,
    input  logic         s_axis_rx_tlast,
    output logic         s_axis_rx_tready,
    output logic         m_axis_meta_valid,
    output logic [63:0]  m_axis_meta_key,
    output logic         m_axis_meta_hit,
    output logic [15:0]  m_axis_meta_len,
    input  logic         m_axis_meta_ready,
    output logic         m_axis_ram_valid,
    output logic [511:0] m_axis_ram_data,
    output logic [63:0]  m_axis_ram_keep,
    output logic         m_axis_ram_last,
    input  logic         m_axis_ram_ready,
    output logic [15:0]  stat_err_cnt
);

    rx_state_t            state_q, state_d;
    logic [15:0]          left_q, left_d, left_sub;
    logic [HOLD_BITS-1:0] hold_q, hold_d;
    logic                 drop_q, drop_d;
    logic [15:0]          err_q;
    logic                 err_inc, rdy, acc, last_in;
    logic [511:0]         beat;
    logic [7:0]           hdr_flag;
    logic [15:0]          hdr_len;
    logic [63:0]          hdr_key;
    meta_t                meta_d, meta_q;
    ram_t                 ram_d, ram_q;
    logic                 meta_load, meta_free;
    logic                 ram_load, ram_free;

    // bytes outside tkeep are forced to zero
    always_comb begin
        for (int i = 0; i < 64; i++)
            beat[8*i +: 8] = s_axis_rx_tdata[8*i +: 8]
                           & {8{s_axis_rx_tkeep[i]}};
    end

    assign hdr_flag = beat[FLAG_LSB +: 8];
    assign hdr_len  = beat[LEN_LSB +: 16];
    assign hdr_key  = beat[KEY_LSB +: 64];
    assign left_sub = left_q - 16'd64;
    assign last_in  = s_axis_rx_tlast;

    always_comb begin
        unique case (state_q)
            ST_IDLE: rdy = meta_free && ram_free;
            ST_BODY: rdy = ram_free;
            ST_DROP: rdy = 1'b1;
            default: rdy = 1'b0;
        endcase
    end

    assign s_axis_rx_tready = rdy && !rst;
    assign acc = s_axis_rx_tvalid && s_axis_rx_tready;

    always_comb begin
        state_d   = state_q;
        left_d    = left_q;
        hold_d    = hold_q;
        drop_d    = drop_q;
        err_inc   = 1'b0;
        meta_load = 1'b0;
        meta_d    = '0;
        ram_load  = 1'b0;
        ram_d     = '0;
        unique case (state_q)
            ST_IDLE: if (acc) begin
                meta_d.key = hdr_key;
                unique case (1'b1)
                    (hdr_flag == FLAG_MISS): begin
                        meta_load = 1'b1;
                        if (!last_in) begin
                            err_inc = 1'b1;
                            state_d = ST_DROP;
                        end
                    end
                    (hdr_flag == FLAG_HIT): begin
                        meta_load  = 1'b1;
                        meta_d.hit = 1'b1;
                        meta_d.len = hdr_len;
                        hold_d     = beat[511:HDR_BITS];
                        left_d     = hdr_len;
                        drop_d     = 1'b0;
                        if (hdr_len == 16'd0) begin
                            if (!last_in) begin
                                err_inc = 1'b1;
                                state_d = ST_DROP;
                            end
                        end else if (hdr_len <= HOLD_LEN) begin
                            state_d = ST_FLUSH;
                            if (!last_in) begin
                                err_inc = 1'b1;
                                drop_d  = 1'b1;
                            end
                        end else if (last_in) begin
                            err_inc = 1'b1;
                            left_d  = HOLD_LEN;
                            state_d = ST_FLUSH;
                        end else begin
                            state_d = ST_BODY;
                        end
                    end
                    default: begin
                        err_inc = 1'b1;
                        if (!last_in)
                            state_d = ST_DROP;
                    end
                endcase
            end
            ST_BODY: if (acc) begin
                ram_load   = 1'b1;
                ram_d.data = {beat[HDR_BITS-1:0], hold_q};
                hold_d     = beat[511:HDR_BITS];
                if (left_q <= 16'd64) begin
                    ram_d.keep = gen_keep(left_q[6:0]);
                    ram_d.last = 1'b1;
                    left_d     = 16'd0;
                    state_d    = ST_IDLE;
                    if (!last_in) begin
                        err_inc = 1'b1;
                        state_d = ST_DROP;
                    end
                end else begin
                    ram_d.keep = gen_keep(7'd64);
                    left_d     = left_sub;
                    if (left_sub <= HOLD_LEN) begin
                        // tail sits entirely in hold
                        state_d = ST_FLUSH;
                        if (!last_in) begin
                            err_inc = 1'b1;
                            drop_d  = 1'b1;
                        end
                    end else if (last_in) begin
                        ram_d.last = 1'b1;
                        err_inc    = 1'b1;
                        left_d     = 16'd0;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: if (ram_free) begin
                ram_load   = 1'b1;
                ram_d.data = {{HDR_BITS{1'b0}}, hold_q};
                ram_d.keep = gen_keep(left_q[6:0]);
                ram_d.last = 1'b1;
                left_d     = 16'd0;
                drop_d     = 1'b0;
                state_d    = drop_q ? ST_DROP : ST_IDLE;
            end
            ST_DROP: if (acc && last_in) begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            left_q  <= '0;
            hold_q  <= '0;
            drop_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            left_q  <= left_d;
            hold_q  <= hold_d;
            drop_q  <= drop_d;
            if (err_inc && err_q != 16'hFFFF)
                err_q <= err_q + 16'd1;
        end
    end

    axis_out_reg #(.W($bits(meta_t))) u_meta (
        .clk   (clk),
        .rst   (rst),
        .load  (meta_load),
        .d     (meta_d),
        .free  (meta_free),
        .valid (m_axis_meta_valid),
        .q     (meta_q),
        .ready (m_axis_meta_ready)
    );

    axis_out_reg #(.W($bits(ram_t))) u_ram (
        .clk   (clk),
        .rst   (rst),
        .load  (ram_load),
        .d     (ram_d),
        .free  (ram_free),
        .valid (m_axis_ram_valid),
        .q     (ram_q),
        .ready (m_axis_ram_ready)
    );

    assign m_axis_meta_key = meta_q.key;
    assign m_axis_meta_hit = meta_q.hit;
    assign m_axis_meta_len = meta_q.len;
    assign m_axis_ram_data = ram_q.data;
    assign m_axis_ram_keep = ram_q.keep;
    assign m_axis_ram_last = ram_q.last;
    assign stat_err_cnt    = err_q;

endmodule

// File: tb/tb_lkp_rep_receiver.sv
// Directed bench for lkp_rep_receiver with meta/ram scoreboards.
// Expected records are queued as frames are built.
module tb_lkp_rep_receiver;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         s_axis_rx_tvalid = 1'b0;
    logic [511:0] s_axis_rx_tdata = '0;
    logic [63:0]  s_axis_rx_tkeep = '0;
    logic         s_axis_rx_tlast = 1'b0;
    logic         s_axis_rx_tready;
    logic         m_axis_meta_valid;
    logic [63:0]  m_axis_meta_key;
    logic         m_axis_meta_hit;
    logic [15:0]  m_axis_meta_len;
    logic         m_axis_meta_ready = 1'b1;
    logic         m_axis_ram_valid;
    logic [511:0] m_axis_ram_data;
    logic [63:0]  m_axis_ram_keep;
    logic         m_axis_ram_last;
    logic         m_axis_ram_ready = 1'b1;
    logic [15:0]  stat_err_cnt;

    int checks = 0;
    int errors = 0;

    logic [80:0]  meta_exp[$];
    logic [576:0] ram_exp[$];
    logic [7:0]   frame[$];

    logic [511:0] snap_d;
    logic [63:0]  snap_k;

    always #5 clk = ~clk;

    lkp_rep_receiver dut (
        .clk               (clk),
        .rst               (rst),
        .s_axis_rx_tvalid  (s_axis_rx_tvalid),
        .s_axis_rx_tdata   (s_axis_rx_tdata),
        .s_axis_rx_tkeep   (s_axis_rx_tkeep),
        .s_axis_rx_tlast   (s_axis_rx_tlast),
        .s_axis_rx_tready  (s_axis_rx_tready),
        .m_axis_meta_valid (m_axis_meta_valid),
        .m_axis_meta_key   (m_axis_meta_key),
        .m_axis_meta_hit   (m_axis_meta_hit),
        .m_axis_meta_len   (m_axis_meta_len),
        .m_axis_meta_ready (m_axis_meta_ready),
        .m_axis_ram_valid  (m_axis_ram_valid),
        .m_axis_ram_data   (m_axis_ram_data),
        .m_axis_ram_keep   (m_axis_ram_keep),
        .m_axis_ram_last   (m_axis_ram_last),
        .m_axis_ram_ready  (m_axis_ram_ready),
        .stat_err_cnt      (stat_err_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic build(input logic [7:0] flag, input logic [15:0] len,
                         input logic [63:0] key, input int total);
        frame.delete();
        frame.push_back(flag);
        frame.push_back(len[7:0]);
        frame.push_back(len[15:8]);
        for (int i = 0; i < 8; i++)
            frame.push_back(key[8*i +: 8]);
        while (frame.size() < total)
            frame.push_back(8'($urandom));
    endtask

    task automatic exp_meta(input logic [63:0] key, input logic hit,
                            input logic [15:0] len);
        meta_exp.push_back({key, hit, len});
    endtask

    task automatic exp_ram(input int nbytes);
        int nw, cnt;
        logic [511:0] d;
        logic [63:0] k;
        nw = (nbytes + 63) / 64;
        for (int w = 0; w < nw; w++) begin
            cnt = nbytes - 64 * w;
            if (cnt > 64) cnt = 64;
            d = '0;
            k = '0;
            for (int b = 0; b < cnt; b++) begin
                d[8*b +: 8] = frame[11 + 64*w + b];
                k[b] = 1'b1;
            end
            ram_exp.push_back({d, k, 1'(w == nw - 1)});
        end
    endtask

    task automatic send_beat(input logic [511:0] d, input logic [63:0] k,
                             input logic l);
        bit got;
        got = 1'b0;
        s_axis_rx_tvalid = 1'b1;
        s_axis_rx_tdata  = d;
        s_axis_rx_tkeep  = k;
        s_axis_rx_tlast  = l;
        for (int n = 0; n < 500 && !got; n++) begin
            @(negedge clk);
            got = s_axis_rx_tready;
            @(posedge clk);
            #1;
        end
        chk("beat_accept", 64'(got), 64'd1);
        s_axis_rx_tvalid = 1'b0;
        s_axis_rx_tdata  = '0;
        s_axis_rx_tkeep  = '0;
        s_axis_rx_tlast  = 1'b0;
    endtask

    task automatic send_frame(input int max_beats);
        int nb;
        logic [511:0] d;
        logic [63:0] k;
        nb = (frame.size() + 63) / 64;
        for (int b = 0; b < nb && b < max_beats; b++) begin
            d = '0;
            k = '0;
            for (int i = 0; i < 64; i++) begin
                if (64 * b + i < frame.size()) begin
                    d[8*i +: 8] = frame[64*b + i];
                    k[i] = 1'b1;
                end
            end
            send_beat(d, k, b == nb - 1);
        end
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 2000; n++) begin
            if (meta_exp.size() == 0 && ram_exp.size() == 0) break;
            @(posedge clk);
        end
        repeat (6) @(posedge clk);
        #1;
        chk({tag, "_meta_left"}, 64'(meta_exp.size()), 64'd0);
        chk({tag, "_ram_left"}, 64'(ram_exp.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        logic [80:0] e;
        if (!rst && m_axis_meta_valid && m_axis_meta_ready) begin
            chk("meta_unexpected", 64'(meta_exp.size() != 0), 64'd1);
            if (meta_exp.size() != 0) begin
                e = meta_exp.pop_front();
                chk("meta_key", m_axis_meta_key, e[80:17]);
                chk("meta_hit_len", {m_axis_meta_hit, m_axis_meta_len},
                    64'(e[16:0]));
            end
        end
    end

    always @(negedge clk) begin
        logic [576:0] e;
        if (!rst && m_axis_ram_valid && m_axis_ram_ready) begin
            chk("ram_unexpected", 64'(ram_exp.size() != 0), 64'd1);
            if (ram_exp.size() != 0) begin
                e = ram_exp.pop_front();
                chk("ram_keep", m_axis_ram_keep, e[64:1]);
                chk("ram_last", 64'(m_axis_ram_last), 64'(e[0]));
                checks++;
                assert (m_axis_ram_data === e[576:65]) else begin
                    errors++;
                    $error("FAIL ram_data obs=%0h exp=%0h",
                           m_axis_ram_data, e[576:65]);
                end
            end
        end
    end

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_meta_valid", 64'(m_axis_meta_valid), 64'd0);
        chk("rst_ram_valid", 64'(m_axis_ram_valid), 64'd0);
        chk("rst_tready", 64'(s_axis_rx_tready), 64'd0);
        chk("rst_err", 64'(stat_err_cnt), 64'd0);
        chk("rst_meta_key", m_axis_meta_key, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // miss with a nonzero len field still reports len 0
        build(8'h00, 16'h0005, 64'h1122334455667788, 11);
        exp_meta(64'h1122334455667788, 1'b0, 16'd0);
        send_frame(99);
        drain("miss");
        chk("miss_err", 64'(stat_err_cnt), 64'd0);

        build(8'hFF, 16'd20, 64'hA5A5_0000_1234_5678, 31);
        exp_meta(64'hA5A5_0000_1234_5678, 1'b1, 16'd20);
        exp_ram(20);
        send_frame(99);
        drain("len20");

        build(8'hFF, 16'd100, 64'h0BAD_CAFE_0000_0100, 111);
        exp_meta(64'h0BAD_CAFE_0000_0100, 1'b1, 16'd100);
        exp_ram(100);
        send_frame(99);
        drain("len100");

        build(8'hFF, 16'd53, 64'h5353_5353_5353_5353, 64);
        exp_meta(64'h5353_5353_5353_5353, 1'b1, 16'd53);
        exp_ram(53);
        send_frame(99);
        drain("len53");

        build(8'hFF, 16'd54, 64'h5454_5454_5454_5454, 65);
        exp_meta(64'h5454_5454_5454_5454, 1'b1, 16'd54);
        exp_ram(54);
        send_frame(99);
        drain("len54");
        chk("bound_err", 64'(stat_err_cnt), 64'd0);

        build(8'hFF, 16'd200, 64'hC8C8_0000_0000_00C8, 211);
        exp_meta(64'hC8C8_0000_0000_00C8, 1'b1, 16'd200);
        exp_ram(200);
        fork
            send_frame(99);
            begin
                repeat (3) @(posedge clk);
                #1;
                m_axis_meta_ready = 1'b0;
                m_axis_ram_ready  = 1'b0;
                repeat (3) @(negedge clk);
                snap_d = m_axis_ram_data;
                snap_k = m_axis_ram_keep;
                chk("bp_ram_valid", 64'(m_axis_ram_valid), 64'd1);
                for (int i = 0; i < 7; i++) begin
                    @(negedge clk);
                    chk("bp_tready", 64'(s_axis_rx_tready), 64'd0);
                    chk("bp_keep_stable", m_axis_ram_keep, snap_k);
                    checks++;
                    assert (m_axis_ram_data === snap_d) else begin
                        errors++;
                        $error("FAIL bp_data_stable obs=%0h exp=%0h",
                               m_axis_ram_data, snap_d);
                    end
                end
                @(posedge clk);
                #1;
                m_axis_meta_ready = 1'b1;
                m_axis_ram_ready  = 1'b1;
            end
        join
        drain("len200");
        chk("bp_err", 64'(stat_err_cnt), 64'd0);

        build(8'h5A, 16'd10, 64'h5A5A_5A5A_5A5A_5A5A, 192);
        send_frame(99);
        drain("badflag");
        chk("badflag_err", 64'(stat_err_cnt), 64'd1);

        build(8'hFF, 16'd300, 64'h0000_0000_0000_012C, 128);
        exp_meta(64'h0000_0000_0000_012C, 1'b1, 16'd300);
        exp_ram(64);
        send_frame(99);
        drain("trunc");
        chk("trunc_err", 64'(stat_err_cnt), 64'd2);

        // stall both outputs, abandon a frame halfway, then reset
        m_axis_meta_ready = 1'b0;
        m_axis_ram_ready  = 1'b0;
        build(8'hFF, 16'd200, 64'hDEAD_0000_0000_BEEF, 211);
        send_frame(2);
        @(negedge clk);
        chk("pre_rst_meta_valid", 64'(m_axis_meta_valid), 64'd1);
        chk("pre_rst_ram_valid", 64'(m_axis_ram_valid), 64'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_meta_valid", 64'(m_axis_meta_valid), 64'd0);
        chk("mid_rst_ram_valid", 64'(m_axis_ram_valid), 64'd0);
        chk("mid_rst_key", m_axis_meta_key, 64'd0);
        chk("mid_rst_err", 64'(stat_err_cnt), 64'd0);
        checks++;
        assert (m_axis_ram_data === 512'd0) else begin
            errors++;
            $error("FAIL mid_rst_data obs=%0h exp=0", m_axis_ram_data);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        m_axis_meta_ready = 1'b1;
        m_axis_ram_ready  = 1'b1;

        build(8'hFF, 16'd100, 64'h0F0F_F0F0_0F0F_F0F0, 111);
        exp_meta(64'h0F0F_F0F0_0F0F_F0F0, 1'b1, 16'd100);
        exp_ram(100);
        send_frame(99);
        drain("post_rst");
        chk("post_rst_err", 64'(stat_err_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
